// File: rtl/frank_pkg.sv
// rtl/frank_pkg.sv - shared constants for the FRANK6000 control unit
package frank_pkg;
    localparam int OVF_DROP = 0;
    localparam int OVF_WRAP = 1;
endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - return-address storage: one sync write port, one async read port
module stack_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/call_return_stack.sv
// rtl/call_return_stack.sv - return-address stack with occupancy, sticky errors and overflow policy
module call_return_stack
    import frank_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RET_OFFSET = 1,
    parameter int OVF_MODE   = OVF_DROP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_PC,
    input  logic                  call,
    input  logic                  rtrn,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] o_Stack,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err,
    output logic                  unf_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic WRAP = (OVF_MODE == OVF_WRAP);

    logic [ADDR_WIDTH-1:0] sp, sp_dec, wr_addr;
    logic [DATA_WIDTH-1:0] ret_addr, top_data;
    logic do_replace, do_push, do_pop, ovf_evt, unf_evt;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign sp_dec   = sp - ADDR_WIDTH'(1);
    assign ret_addr = i_PC + DATA_WIDTH'(RET_OFFSET);

    // Priority flush > call&rtrn > call > rtrn; call&rtrn on an empty stack is a plain push.
    always_comb begin
        do_replace = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (!flush) begin
            if (call && rtrn && !empty) begin
                do_replace = 1'b1;
            end else if (call) begin
                do_push = !full || WRAP;
                ovf_evt = full;
            end else if (rtrn) begin
                do_pop  = !empty;
                unf_evt = empty;
            end
        end
    end

    assign wr_addr = do_replace ? sp_dec : sp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (flush) begin
                sp    <= '0;
                count <= '0;
            end else if (do_push) begin
                sp <= sp + ADDR_WIDTH'(1);
                if (!full) begin
                    count <= count + 1'b1;
                end
            end else if (do_pop) begin
                sp    <= sp_dec;
                count <= count - 1'b1;
            end
            // Set wins over clear when an error lands in the same cycle as clr_err.
            ovf_err <= ovf_evt || (ovf_err && !clr_err);
            unf_err <= unf_evt || (unf_err && !clr_err);
        end
    end

    stack_regfile #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regfile (
        .clk  (clk),
        .we   (do_push || do_replace),
        .waddr(wr_addr),
        .din  (ret_addr),
        .raddr(sp_dec),
        .rdata(top_data)
    );

    assign o_Stack = empty ? '0 : top_data;
endmodule

// File: tb/tb_call_return_stack.sv
// tb/tb_call_return_stack.sv - DROP and WRAP stacks against a list model
module tb_call_return_stack;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] i_PC = '0;
    logic          call = 1'b0, rtrn = 1'b0, flush = 1'b0, clr_err = 1'b0;

    logic [DW-1:0] ostk   [2];
    logic [AW:0]   cnt    [2];
    logic          fl     [2];
    logic          em     [2];
    logic          ovf    [2];
    logic          unf    [2];

    // Model: lst[m][0] is the oldest entry, lst[m][sz[m]-1] the top.
    logic [DW-1:0] lst [2][DEPTH];
    int            sz  [2];
    bit            movf[2];
    bit            munf[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_return_stack #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RET_OFFSET(1), .OVF_MODE(0)) u_drop (
        .clk(clk), .rst(rst), .i_PC(i_PC), .call(call), .rtrn(rtrn), .flush(flush),
        .clr_err(clr_err), .o_Stack(ostk[0]), .count(cnt[0]), .full(fl[0]), .empty(em[0]),
        .ovf_err(ovf[0]), .unf_err(unf[0])
    );

    call_return_stack #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RET_OFFSET(1), .OVF_MODE(1)) u_wrap (
        .clk(clk), .rst(rst), .i_PC(i_PC), .call(call), .rtrn(rtrn), .flush(flush),
        .clr_err(clr_err), .o_Stack(ostk[1]), .count(cnt[1]), .full(fl[1]), .empty(em[1]),
        .ovf_err(ovf[1]), .unf_err(unf[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            sz[m] = 0; movf[m] = 0; munf[m] = 0;
        end
    endtask

    task automatic model_step();
        logic [DW-1:0] ra;
        bit oe, ue;
        ra = i_PC + 8'd1;
        for (int m = 0; m < 2; m++) begin
            oe = 0; ue = 0;
            if (flush) begin
                sz[m] = 0;
            end else if (call && rtrn && sz[m] > 0) begin
                lst[m][sz[m]-1] = ra;
            end else if (call) begin
                if (sz[m] < DEPTH) begin
                    lst[m][sz[m]] = ra;
                    sz[m]++;
                end else begin
                    oe = 1;
                    if (m == 1) begin
                        for (int k = 0; k < DEPTH - 1; k++) lst[m][k] = lst[m][k+1];
                        lst[m][DEPTH-1] = ra;
                    end
                end
            end else if (rtrn) begin
                if (sz[m] > 0) sz[m]--;
                else ue = 1;
            end
            if (clr_err) begin
                movf[m] = 0; munf[m] = 0;
            end
            if (oe) movf[m] = 1;
            if (ue) munf[m] = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s.m%0d.count", tag, m), 32'(cnt[m]), 32'(sz[m]));
            check($sformatf("%s.m%0d.top", tag, m), 32'(ostk[m]),
                  (sz[m] > 0) ? 32'(lst[m][sz[m]-1]) : 32'd0);
            check($sformatf("%s.m%0d.full", tag, m), 32'(fl[m]), 32'(sz[m] == DEPTH));
            check($sformatf("%s.m%0d.empty", tag, m), 32'(em[m]), 32'(sz[m] == 0));
            check($sformatf("%s.m%0d.ovf", tag, m), 32'(ovf[m]), 32'(movf[m]));
            check($sformatf("%s.m%0d.unf", tag, m), 32'(unf[m]), 32'(munf[m]));
        end
    endtask

    // Inputs are applied at the negedge; state is compared at the following negedge.
    task automatic drive(input logic c, input logic r, input logic f, input logic ce,
                         input logic [DW-1:0] pc, input string tag);
        call = c; rtrn = r; flush = f; clr_err = ce; i_PC = pc;
        @(posedge clk);
        model_step();
        @(negedge clk);
        call = 0; rtrn = 0; flush = 0; clr_err = 0;
        compare_all(tag);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all("reset");
        rst = 1'b1;
        @(negedge clk);

        drive(1, 0, 0, 0, 8'd10, "lifo.push");
        drive(1, 0, 0, 0, 8'd20, "lifo.push");
        drive(1, 0, 0, 0, 8'd30, "lifo.push");
        check("lifo.top3", 32'(ostk[0]), 32'd31);
        drive(0, 1, 0, 0, 8'd0, "lifo.pop");
        check("lifo.pop1", 32'(ostk[0]), 32'd21);
        drive(0, 1, 0, 0, 8'd0, "lifo.pop");
        check("lifo.pop2", 32'(ostk[0]), 32'd11);
        drive(0, 1, 0, 0, 8'd0, "lifo.pop");
        check("lifo.pop3", 32'(ostk[0]), 32'd0);
        check("lifo.empty", 32'(em[0]), 32'd1);

        for (int i = 1; i <= 3; i++) drive(1, 0, 0, 0, 8'(i), "mid.push");
        drive(0, 1, 0, 0, 8'd0, "mid.pop");
        drive(0, 1, 0, 0, 8'd0, "mid.pop");
        drive(0, 1, 0, 0, 8'd0, "mid.pop");
        drive(0, 1, 0, 0, 8'd0, "mid.unf");
        for (int i = 1; i <= 3; i++) drive(1, 0, 0, 0, 8'(i), "rst.push");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst.count", 32'(cnt[0]), 32'd0);
        check("rst.empty", 32'(em[0]), 32'd1);
        check("rst.top", 32'(ostk[1]), 32'd0);
        check("rst.unf", 32'(unf[0]), 32'd0);
        compare_all("rst.async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 5; i++) drive(1, 0, 0, 0, 8'(i), "ovf.push");
        check("drop.count", 32'(cnt[0]), 32'd4);
        check("drop.top", 32'(ostk[0]), 32'd5);
        check("drop.ovf", 32'(ovf[0]), 32'd1);
        check("wrap.count", 32'(cnt[1]), 32'd4);
        check("wrap.top", 32'(ostk[1]), 32'd6);
        check("wrap.ovf", 32'(ovf[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drop.pop%0d", i), 32'(ostk[0]), 32'(5 - i));
            check($sformatf("wrap.pop%0d", i), 32'(ostk[1]), 32'(6 - i));
            drive(0, 1, 0, 0, 8'd0, "ovf.pop");
        end

        drive(0, 0, 0, 1, 8'd0, "unf.clr0");
        drive(0, 1, 0, 0, 8'd0, "unf.pop");
        check("unf.set", 32'(unf[0]), 32'd1);
        check("unf.count", 32'(cnt[0]), 32'd0);
        drive(0, 0, 0, 1, 8'd0, "unf.clr");
        check("unf.cleared", 32'(unf[0]), 32'd0);
        drive(0, 1, 0, 1, 8'd0, "unf.setwins");
        check("unf.setwins", 32'(unf[0]), 32'd1);

        drive(1, 0, 0, 0, 8'h40, "rep.push");
        drive(1, 1, 0, 0, 8'hFF, "rep.replace");
        check("rep.count", 32'(cnt[0]), 32'd1);
        check("rep.top", 32'(ostk[0]), 32'h00);
        drive(1, 0, 1, 0, 8'h22, "rep.flush");
        check("flush.count", 32'(cnt[0]), 32'd0);
        drive(1, 1, 0, 0, 8'h7E, "rep.empty_both");
        check("rep.empty_top", 32'(ostk[0]), 32'h7F);

        for (int i = 0; i < 600; i++) begin
            logic c, r, f, ce;
            c  = ($urandom_range(0, 99) < 50);
            r  = ($urandom_range(0, 99) < 45);
            f  = ($urandom_range(0, 99) < 4);
            ce = ($urandom_range(0, 99) < 8);
            drive(c, r, f, ce, 8'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
